// File: rtl/keypad_pkg.sv
// Shared key codes, FSM state encoding and display selects for the keypad
// operand-entry path.
package keypad_pkg;

    localparam logic [3:0] KEY_PLUS = 4'hA;
    localparam logic [3:0] KEY_EQ   = 4'hB;
    localparam logic [3:0] KEY_CLR  = 4'hC;

    typedef enum logic [1:0] {
        ENTER_A,
        ENTER_B,
        ADD,
        SHOW
    } entry_state_t;

    localparam logic [1:0] DISP_A   = 2'd0;
    localparam logic [1:0] DISP_B   = 2'd1;
    localparam logic [1:0] DISP_SUM = 2'd2;

    // Codes 0-9 are decimal digits; everything above is a command or unused.
    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Single-digit BCD adder: binary add, then +6 correction when the raw sum
// leaves the decimal range. Operands are assumed to be valid BCD digits.
module bcd_digit_adder (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_s,
    output logic       o_cout
);

    logic [4:0] w_raw;

    assign w_raw = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};

    // Decimal correction: raw 10..19 wraps into 0..9 with a carry out.
    always_comb begin
        o_s    = w_raw[3:0];
        o_cout = 1'b0;
        if (w_raw > 5'd9) begin
            o_s    = 4'(w_raw + 5'd6);
            o_cout = 1'b1;
        end
    end

endmodule

// File: rtl/operand_entry.sv
// Keypad operand entry: collects two packed-BCD operands from digit keys and
// adds them digit-serially (one BCD digit per cycle) when '=' is pressed.
module operand_entry
    import keypad_pkg::*;
#(
    parameter int N_DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [3:0]                key_code,
    input  logic                      key_valid,
    output logic [4*N_DIGITS-1:0]     operand_a,
    output logic [4*N_DIGITS-1:0]     operand_b,
    output logic [4*(N_DIGITS+1)-1:0] sum,
    output logic                      sum_valid,
    output logic                      busy,
    output logic [1:0]                display_sel
);

    localparam int W  = 4*N_DIGITS;
    localparam int CW = $clog2(N_DIGITS+1);

    entry_state_t           r_state;
    entry_state_t           w_state_nxt;
    logic                   r_kv_q;
    logic [W-1:0]           r_a;
    logic [W-1:0]           r_b;
    logic [W+3:0]           r_sum;
    logic [CW-1:0]          r_cnt;
    logic                   r_carry;
    logic                   r_sum_valid;

    logic                   w_key_ev;
    logic                   w_is_digit;
    logic                   w_room;
    logic                   w_clear;
    logic                   w_shift_a;
    logic                   w_shift_b;
    logic                   w_go_b;
    logic                   w_start_add;
    logic                   w_add_step;
    logic                   w_add_last;
    logic                   w_restart;
    logic [3:0]             w_a_dig;
    logic [3:0]             w_b_dig;
    logic [3:0]             w_s_dig;
    logic                   w_cout;

    // One event per press: only the rising edge of key_valid counts.
    assign w_key_ev   = key_valid & ~r_kv_q;
    assign w_is_digit = is_digit(key_code);
    assign w_room     = (r_cnt < CW'(N_DIGITS));

    // Select the operand digits for the current add position.
    always_comb begin
        w_a_dig = 4'd0;
        w_b_dig = 4'd0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_cnt == CW'(i)) begin
                w_a_dig = r_a[4*i +: 4];
                w_b_dig = r_b[4*i +: 4];
            end
        end
    end

    bcd_digit_adder u_digit_add (
        .i_a    (w_a_dig),
        .i_b    (w_b_dig),
        .i_cin  (r_carry),
        .o_s    (w_s_dig),
        .o_cout (w_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ENTER_A;
        else      r_state <= w_state_nxt;
    end

    // Next-state and datapath control decode; key events in ADD are dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_shift_a   = 1'b0;
        w_shift_b   = 1'b0;
        w_go_b      = 1'b0;
        w_start_add = 1'b0;
        w_add_step  = 1'b0;
        w_add_last  = 1'b0;
        w_restart   = 1'b0;
        case (r_state)
            ENTER_A: begin
                if (w_key_ev) begin
                    if (key_code == KEY_CLR) begin
                        w_clear = 1'b1;
                    end else if (w_is_digit) begin
                        w_shift_a = 1'b1;
                    end else if (key_code == KEY_PLUS) begin
                        w_go_b      = 1'b1;
                        w_state_nxt = ENTER_B;
                    end else if (key_code == KEY_EQ) begin
                        w_start_add = 1'b1;
                        w_state_nxt = ADD;
                    end
                end
            end
            ENTER_B: begin
                if (w_key_ev) begin
                    if (key_code == KEY_CLR) begin
                        w_clear     = 1'b1;
                        w_state_nxt = ENTER_A;
                    end else if (w_is_digit) begin
                        w_shift_b = 1'b1;
                    end else if (key_code == KEY_EQ) begin
                        w_start_add = 1'b1;
                        w_state_nxt = ADD;
                    end
                end
            end
            ADD: begin
                w_add_step = 1'b1;
                if (r_cnt == CW'(N_DIGITS-1)) begin
                    w_add_last  = 1'b1;
                    w_state_nxt = SHOW;
                end
            end
            SHOW: begin
                if (w_key_ev) begin
                    if (key_code == KEY_CLR) begin
                        w_clear     = 1'b1;
                        w_state_nxt = ENTER_A;
                    end else if (w_is_digit) begin
                        w_restart   = 1'b1;
                        w_state_nxt = ENTER_A;
                    end
                end
            end
            default: w_state_nxt = ENTER_A;
        endcase
    end

    // Operand shift registers, digit-serial sum accumulation and done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_kv_q      <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_sum_valid <= 1'b0;
        end else begin
            // Edge register keeps tracking in every state so a key held
            // through ADD does not fire once ADD ends.
            r_kv_q      <= key_valid;
            r_sum_valid <= 1'b0;
            if (w_clear) begin
                r_a     <= '0;
                r_b     <= '0;
                r_sum   <= '0;
                r_cnt   <= '0;
                r_carry <= 1'b0;
            end else if (w_shift_a) begin
                // Full operand: extra digits are ignored, not wrapped.
                if (w_room) begin
                    r_a   <= (r_a << 4) | W'(key_code);
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (w_shift_b) begin
                if (w_room) begin
                    r_b   <= (r_b << 4) | W'(key_code);
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (w_go_b) begin
                r_cnt <= '0;
            end else if (w_start_add) begin
                // '=' straight from A adds A + 0.
                if (r_state == ENTER_A) r_b <= '0;
                r_sum   <= '0;
                r_cnt   <= '0;
                r_carry <= 1'b0;
            end else if (w_add_step) begin
                for (int i = 0; i < N_DIGITS; i++) begin
                    if (r_cnt == CW'(i)) r_sum[4*i +: 4] <= w_s_dig;
                end
                r_carry <= w_cout;
                r_cnt   <= r_cnt + 1'b1;
                if (w_add_last) begin
                    r_sum[W +: 4] <= {3'b000, w_cout};
                    r_sum_valid   <= 1'b1;
                end
            end else if (w_restart) begin
                // A digit after a result starts a new calculation with it.
                r_a     <= W'(key_code);
                r_b     <= '0;
                r_sum   <= '0;
                r_cnt   <= CW'(1);
                r_carry <= 1'b0;
            end
        end
    end

    // Display select follows the state; ADD keeps showing B.
    always_comb begin
        display_sel = DISP_A;
        case (r_state)
            ENTER_A: display_sel = DISP_A;
            ENTER_B: display_sel = DISP_B;
            ADD:     display_sel = DISP_B;
            SHOW:    display_sel = DISP_SUM;
            default: display_sel = DISP_A;
        endcase
    end

    assign operand_a = r_a;
    assign operand_b = r_b;
    assign sum       = r_sum;
    assign sum_valid = r_sum_valid;
    assign busy      = (r_state == ADD);

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry: decimal reference model of the calculator,
// scoreboard queue for sum results checked by an independent monitor.
module tb_operand_entry;

    localparam int N = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    key_code = 4'd0;
    logic          key_valid = 1'b0;
    logic [4*N-1:0] operand_a, operand_b;
    logic [4*N+3:0] sum;
    logic          sum_valid, busy;
    logic [1:0]    display_sel;

    operand_entry #(.N_DIGITS(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .sum         (sum),
        .sum_valid   (sum_valid),
        .busy        (busy),
        .display_sel (display_sel)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: operands held as plain decimal integers.
    int m_a, m_b, m_sum, m_cnt, m_mode;   // mode 0=A entry, 1=B entry, 2=showing result
    int add_end = -100;                   // last clock edge that belongs to an add

    typedef struct {
        logic [31:0] sum;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_a = 0; m_b = 0; m_sum = 0; m_cnt = 0; m_mode = 0;
    endtask

    task automatic model_start_add(input int ev);
        exp_t e;
        m_sum   = m_a + m_b;
        add_end = ev + N;
        m_mode  = 2;
        e.sum   = to_bcd(m_sum);
        e.cyc   = ev + N;
        sb.push_back(e);
    endtask

    // Apply one key event occurring at clock edge number ev.
    task automatic model_key(input int k, input int ev);
        if (ev <= add_end) return;
        if (k == 12) begin
            model_reset();
            return;
        end
        case (m_mode)
            0: begin
                if (k <= 9) begin
                    if (m_cnt < N) begin m_a = m_a*10 + k; m_cnt++; end
                end else if (k == 10) begin
                    m_mode = 1; m_cnt = 0;
                end else if (k == 11) begin
                    m_b = 0; model_start_add(ev);
                end
            end
            1: begin
                if (k <= 9) begin
                    if (m_cnt < N) begin m_b = m_b*10 + k; m_cnt++; end
                end else if (k == 11) begin
                    model_start_add(ev);
                end
            end
            default: begin
                if (k <= 9) begin
                    m_a = k; m_b = 0; m_sum = 0; m_cnt = 1; m_mode = 0;
                end
            end
        endcase
    endtask

    task automatic press(input int k, input int hold, input int gap);
        int ev, prev_end;
        @(negedge clk);
        key_code  = 4'(k);
        key_valid = 1'b1;
        ev = cyc + 1;
        prev_end = add_end;
        model_key(k, ev);
        @(negedge clk);
        if (add_end != prev_end) begin
            chk("busy_in_add", 32'(busy), 32'd1);
            chk("disp_in_add", 32'(display_sel), 32'd1);
        end
        repeat (hold-1) @(negedge clk);
        key_valid = 1'b0;
        repeat (gap) @(negedge clk);
        chk("operand_a", 32'(operand_a), to_bcd(m_a));
        chk("operand_b", 32'(operand_b), to_bcd(m_b));
        if (gap >= 4) begin
            chk("display_sel", 32'(display_sel), 32'(m_mode));
            chk("busy_idle", 32'(busy), 32'd0);
            chk("sum_reg", 32'(sum), to_bcd(m_sum));
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a"},    32'(operand_a),   32'd0);
        chk({tag, "_b"},    32'(operand_b),   32'd0);
        chk({tag, "_sum"},  32'(sum),         32'd0);
        chk({tag, "_sv"},   32'(sum_valid),   32'd0);
        chk({tag, "_busy"}, 32'(busy),        32'd0);
        chk({tag, "_disp"}, 32'(display_sel), 32'd0);
    endtask

    // Monitor: every sum_valid pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (sum_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_sum_valid: got pulse with sum %0h, expected none", sum);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sum", 32'(sum), e.sum);
                chk("sum_latency_cycle", 32'(cyc), 32'(e.cyc));
                chk("disp_at_valid", 32'(display_sel), 32'd2);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        // Reset behaviour.
        #2 rst = 1'b0;
        #1 chk_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero("after_reset");

        // Digit entry saturates at N digits, then clear.
        press(1, 2, 4); press(2, 2, 4); press(3, 2, 4); press(4, 2, 4);
        chk("a_123", 32'(operand_a), 32'h123);
        press(12, 2, 4);
        chk("a_cleared", 32'(operand_a), 32'h0);

        // 12 + 99.
        press(1, 2, 4); press(2, 2, 4); press(10, 2, 4);
        press(9, 2, 4); press(9, 2, 4);
        press(11, 2, 6);
        chk("b_099", 32'(operand_b), 32'h099);
        chk("sum_0111", 32'(sum), 32'h0111);

        // 999 + 999.
        press(12, 2, 4);
        for (int i = 0; i < 3; i++) press(9, 1, 4);
        press(10, 1, 4);
        for (int i = 0; i < 3; i++) press(9, 3, 4);
        press(11, 1, 6);
        chk("sum_1998", 32'(sum), 32'h1998);

        // Long hold gives one event; a key pressed and held across ADD is dropped.
        press(12, 2, 4);
        press(5, 50, 5);
        chk("a_005", 32'(operand_a), 32'h005);
        press(10, 2, 4); press(3, 2, 4);
        press(11, 1, 0);
        press(7, 8, 6);
        chk("a_after_add", 32'(operand_a), 32'h005);
        chk("sum_0008", 32'(sum), 32'h0008);

        // Reset during the second ADD cycle abandons the add.
        press(12, 2, 4);
        press(4, 2, 4); press(10, 2, 4); press(5, 2, 4);
        press(11, 1, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk_zero("mid_add_reset");
        sb.delete();
        model_reset();
        add_end = -100;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        chk_zero("after_mid_add_reset");

        // Randomized key sequences against the decimal model.
        for (int i = 0; i < 80; i++) begin
            int k;
            k = $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) k = $urandom_range(10, 12);
            press(k, $urandom_range(1, 3), $urandom_range(4, 6));
        end

        repeat (6) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
